// File: rtl/utils_pkg.sv
// utils_pkg: AXI4 slave channel structs, response codes and GPIO CSR register map
package utils_pkg;
  localparam int ID_W = 4;
  localparam logic [4:0] OFF_OUT = 5'h00;
  localparam logic [4:0] OFF_IN = 5'h04;
  localparam logic [4:0] OFF_MASK = 5'h08;
  localparam logic [4:0] OFF_STAT = 5'h0C;
  localparam logic [4:0] OFF_SCRATCH = 5'h10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef struct packed {
    logic [ID_W-1:0] awid;
    logic [31:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic wlast;
    logic wvalid;
    logic bready;
    logic [ID_W-1:0] arid;
    logic [31:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arvalid;
    logic rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic awready;
    logic wready;
    logic [ID_W-1:0] bid;
    logic [1:0] bresp;
    logic bvalid;
    logic arready;
    logic [ID_W-1:0] rid;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rlast;
    logic rvalid;
  } s_axi_miso_t;
  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
endpackage

// File: rtl/cdc_2ff_sync.sv
// cdc_2ff_sync: two-flop synchronizer for asynchronous level inputs
module cdc_2ff_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/axi_gpio_csr.sv
// axi_gpio_csr: AXI4 slave register block for GPIO out/in, edge interrupts and scratch
module axi_gpio_csr
  import utils_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  s_axi_mosi_t       axi_mosi,
  output s_axi_miso_t       axi_miso,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              irq_o
);
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;
  logic [1:0] w_state;
  logic r_state;
  logic live;
  logic aw_held, w_held;
  logic [ID_W-1:0] aw_id, b_id, r_id;
  logic [31:0] aw_addr, w_data, scratch_q, r_data;
  logic [7:0] aw_len, r_len, r_cnt;
  logic [3:0] w_strb;
  logic [1:0] b_resp, r_resp;
  logic [GPIO_W-1:0] out_q, mask_q, stat_q, in_s, in_d;
  logic [31:0] w_off, r_off, wm, rd_word;
  logic [GPIO_W-1:0] m, clr, rise;
  logic w_ok, r_ok, commit, wr, aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last;
  logic unused;
  assign unused = ^{axi_mosi.awsize, axi_mosi.awburst, axi_mosi.arsize, axi_mosi.arburst,
                    w_off[1:0], r_off[1:0]};
  cdc_2ff_sync #(.W(GPIO_W)) u_sync (
    .clk(clk),
    .arst_n(arst_n),
    .d(gpio_i),
    .q(in_s)
  );
  // address decode, handshakes, read mux and response channel outputs
  always_comb begin
    w_off = aw_addr - BASE_ADDR;
    r_off = axi_mosi.araddr - BASE_ADDR;
    w_ok = w_off[31:5] == '0 && w_off[4:2] <= 3'd4 && aw_len == '0;
    r_ok = r_off[31:5] == '0 && r_off[4:2] <= 3'd4 && axi_mosi.arlen == '0;
    commit = w_state == W_DATA && aw_held && w_held;
    wr = commit && w_ok;
    wm = byte_mask(w_strb);
    m = wm[GPIO_W-1:0];
    clr = (wr && w_off[4:0] == OFF_STAT) ? w_data[GPIO_W-1:0] & m : '0;
    rise = in_s & ~in_d;
    rd_word = r_off[4:0] == OFF_OUT  ? 32'(out_q)  :
              r_off[4:0] == OFF_IN   ? 32'(in_s)   :
              r_off[4:0] == OFF_MASK ? 32'(mask_q) :
              r_off[4:0] == OFF_STAT ? 32'(stat_q) : scratch_q;
    r_last = r_cnt == r_len;
    axi_miso.awready = live && w_state != W_RESP && !aw_held;
    axi_miso.wready = live && w_state != W_RESP && !w_held;
    axi_miso.bvalid = w_state == W_RESP;
    axi_miso.bid = b_id;
    axi_miso.bresp = b_resp;
    axi_miso.arready = live && r_state == R_IDLE;
    axi_miso.rvalid = r_state == R_DATA;
    axi_miso.rid = r_id;
    axi_miso.rdata = r_data;
    axi_miso.rresp = r_resp;
    axi_miso.rlast = r_last;
    aw_hs = axi_mosi.awvalid && axi_miso.awready;
    w_hs = axi_mosi.wvalid && axi_miso.wready;
    b_hs = axi_miso.bvalid && axi_mosi.bready;
    ar_hs = axi_mosi.arvalid && axi_miso.arready;
    r_hs = axi_miso.rvalid && axi_mosi.rready;
    gpio_o = out_q;
    irq_o = |(stat_q & mask_q);
  end
  // write path: capture AW and final W beat independently, then respond once
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_id <= '0;
      aw_addr <= '0;
      aw_len <= '0;
      w_data <= '0;
      w_strb <= '0;
      b_id <= '0;
      b_resp <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_id <= axi_mosi.awid;
        aw_addr <= axi_mosi.awaddr;
        aw_len <= axi_mosi.awlen;
      end
      if (w_hs && axi_mosi.wlast) begin
        w_held <= 1'b1;
        w_data <= axi_mosi.wdata;
        w_strb <= axi_mosi.wstrb;
      end
      if (commit) begin
        b_id <= aw_id;
        b_resp <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
      w_state <= commit ? W_RESP : b_hs ? W_IDLE :
                 (w_state == W_IDLE && (aw_hs || w_hs)) ? W_DATA : w_state;
    end
  // register file; a fresh rising edge beats a simultaneous W1C
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      live <= 1'b0;
      out_q <= '0;
      mask_q <= '0;
      stat_q <= '0;
      in_d <= '0;
      scratch_q <= '0;
    end else begin
      live <= 1'b1;
      in_d <= in_s;
      stat_q <= (stat_q & ~clr) | rise;
      if (wr && w_off[4:0] == OFF_OUT) out_q <= (out_q & ~m) | (w_data[GPIO_W-1:0] & m);
      if (wr && w_off[4:0] == OFF_MASK) mask_q <= (mask_q & ~m) | (w_data[GPIO_W-1:0] & m);
      if (wr && w_off[4:0] == OFF_SCRATCH) scratch_q <= (scratch_q & ~wm) | (w_data & wm);
    end
  // read path: sample data at AR handshake, stream arlen+1 beats
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      r_state <= R_IDLE;
      r_id <= '0;
      r_data <= '0;
      r_resp <= RESP_OKAY;
      r_len <= '0;
      r_cnt <= '0;
    end else if (ar_hs) begin
      r_state <= R_DATA;
      r_id <= axi_mosi.arid;
      r_data <= r_ok ? rd_word : '0;
      r_resp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      r_len <= axi_mosi.arlen;
      r_cnt <= '0;
    end else if (r_hs) begin
      r_state <= r_last ? R_IDLE : R_DATA;
      r_cnt <= r_cnt + 8'd1;
    end
endmodule
